rng_ci_master: RTL and testbench

- Hardware initiator for the RNG Nios II custom-instruction interface (clk_en/start/dataa/datab/result/done).
- Lets a non-CPU client (button panel, UART command path) request a batch of 1–15 dice rolls.
- Per roll: issues one custom-instruction transaction to the RNG core, range-checks the result, reports it, and accumulates a batch sum.
- Sits between the command source and the RNG core instance, in place of the CPU.

---
 rtl/rng_ci_master.sv | 187 ++++++++++++++++++
 tb/tb_rng_ci_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_ci_master.sv
// rng_ci_master: drives the RNG custom-instruction port on behalf of a
// non-CPU client. It runs a batch of dice rolls, range-checks each result,
// reports every roll and then reports the batch sum.
module rng_ci_master #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 4,
    parameter int SUM_W          = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_die,
    input  logic [3:0]       cmd_count,
    output logic             ci_clk_en,
    output logic             ci_start,
    output logic [31:0]      ci_dataa,
    output logic [31:0]      ci_datab,
    input  logic [31:0]      ci_result,
    input  logic             ci_done,
    output logic             roll_valid,
    output logic [6:0]       roll_value,
    output logic [3:0]       roll_index,
    output logic             sum_valid,
    output logic [SUM_W-1:0] sum_value,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // The timer holds cycles elapsed since ci_start, so the last cycle a done
    // is accepted is TIMEOUT_CYCLES-1 and err lands exactly TIMEOUT_CYCLES
    // after ci_start.
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       die_q, count_q, rolls_q;
    logic [6:0]       faces_q;
    logic [TMR_W-1:0] tmr_q;
    logic             ok_q;
    logic [SUM_W-1:0] acc_q;

    logic accept, cmd_ok, capture, timeout, res_ok, last_roll;
    logic [SUM_W-1:0] sum_next;

    function automatic logic [6:0] faces(input logic [3:0] die);
        case (die)
            4'd0:    faces = 7'd4;
            4'd1:    faces = 7'd6;
            4'd2:    faces = 7'd8;
            4'd3:    faces = 7'd10;
            4'd4:    faces = 7'd12;
            4'd5:    faces = 7'd20;
            4'd6:    faces = 7'd100;
            default: faces = 7'd0;
        endcase
    endfunction

    assign accept    = (state_q == IDLE) && cmd_valid;
    assign cmd_ok    = (cmd_die <= 4'd6) && (cmd_count != 4'd0);
    // ISSUE is included so a zero-latency slave's done is taken with ci_start.
    assign capture   = ((state_q == ISSUE) || (state_q == WAIT)) && ci_done;
    assign timeout   = (state_q == WAIT) && !ci_done && (tmr_q == TMO_LAST);
    assign res_ok    = (ci_result[31:7] == 25'd0) && (ci_result[6:0] != 7'd0) &&
                       (ci_result[6:0] <= faces_q);
    assign last_roll = (rolls_q == count_q);
    assign sum_next  = acc_q + {{(SUM_W-7){1'b0}}, roll_value};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        ci_start  = 1'b0;
        ci_clk_en = 1'b0;
        sum_valid = 1'b0;
        ci_dataa  = {28'd0, die_q};
        ci_datab  = 32'd0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept && cmd_ok) state_d = ISSUE;
            end
            ISSUE: begin
                ci_start  = 1'b1;
                ci_clk_en = 1'b1;
                state_d   = ci_done ? CHECK : WAIT;
            end
            WAIT: begin
                ci_clk_en = 1'b1;
                if (ci_done)      state_d = CHECK;
                else if (timeout) state_d = IDLE;
            end
            CHECK: begin
                if (!ok_q)                 state_d = IDLE;
                else if (last_roll)        state_d = DONE;
                else if (GAP_CYCLES == 0)  state_d = ISSUE;
                else                       state_d = GAP;
            end
            GAP: begin
                if (tmr_q == GAP_LAST) state_d = ISSUE;
            end
            DONE: begin
                sum_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared timer: transaction timeout in ISSUE/WAIT, idle spacing in GAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr_q <= '0;
        end else begin
            case (state_q)
                ISSUE:     tmr_q <= TMR_W'(1);
                WAIT, GAP: tmr_q <= tmr_q + TMR_W'(1);
                default:   tmr_q <= '0;
            endcase
        end
    end

    // Command latch, result capture, roll/sum/error reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            die_q      <= '0;
            count_q    <= '0;
            faces_q    <= '0;
            rolls_q    <= '0;
            ok_q       <= 1'b0;
            acc_q      <= '0;
            roll_valid <= 1'b0;
            roll_value <= '0;
            roll_index <= '0;
            sum_value  <= '0;
            err        <= 1'b0;
            err_code   <= '0;
        end else begin
            roll_valid <= 1'b0;
            err        <= 1'b0;
            if (accept) begin
                die_q   <= cmd_die;
                count_q <= cmd_count;
                faces_q <= faces(cmd_die);
                rolls_q <= '0;
                acc_q   <= '0;
                if (cmd_ok) begin
                    err_code <= 2'd0;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'd1;
                end
            end
            // Result is judged on capture so roll_valid/err appear in CHECK.
            if (capture) begin
                ok_q <= res_ok;
                if (res_ok) begin
                    roll_valid <= 1'b1;
                    roll_value <= ci_result[6:0];
                    roll_index <= rolls_q + 4'd1;
                    rolls_q    <= rolls_q + 4'd1;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'd3;
                end
            end
            if (timeout) begin
                err      <= 1'b1;
                err_code <= 2'd2;
            end
            if ((state_q == CHECK) && ok_q) begin
                acc_q <= sum_next;
                if (last_roll) sum_value <= sum_next;
            end
        end
    end

endmodule

// File: tb/tb_rng_ci_master.sv
// Directed bench for rng_ci_master with a behavioural RNG slave and an
// event monitor; expected values are hand-computed per scenario.
module tb_rng_ci_master;
    localparam int TMO = 64;
    localparam int GAP = 4;
    localparam int SW  = 11;

    logic          clk, reset_n;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_die, cmd_count;
    logic          ci_clk_en, ci_start, ci_done;
    logic [31:0]   ci_dataa, ci_datab, ci_result;
    logic          roll_valid, sum_valid, err;
    logic [6:0]    roll_value;
    logic [3:0]    roll_index;
    logic [SW-1:0] sum_value;
    logic [1:0]    err_code;

    rng_ci_master #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .SUM_W(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_die(cmd_die), .cmd_count(cmd_count),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab),
        .ci_result(ci_result), .ci_done(ci_done),
        .roll_valid(roll_valid), .roll_value(roll_value), .roll_index(roll_index),
        .sum_valid(sum_valid), .sum_value(sum_value),
        .err(err), .err_code(err_code)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // RNG slave: answers each ci_start after slave_lat cycles (0 = same
    // cycle, negative = never) with the next queued result.
    int          slave_lat = 3;
    logic [31:0] slave_q[$];

    initial begin
        ci_done = 0;
        ci_result = 0;
        forever begin
            @(negedge clk);
            if (ci_start && slave_lat >= 0) begin
                repeat (slave_lat) @(negedge clk);
                ci_result = (slave_q.size() > 0) ? slave_q.pop_front() : 32'd0;
                ci_done = 1;
                @(negedge clk);
                ci_done = 0;
                ci_result = 0;
            end
        end
    end

    // Monitor: counts and logs DUT strobes, sampled on the falling edge
    int cyc = 0, n_start = 0, n_roll = 0, n_sum = 0, n_err = 0;
    int start_cyc = 0, roll_cyc = 0, sum_cyc = 0, err_cyc = 0;
    int last_sum = 0, last_err_code = 0, gap_run = 0;
    int dataa_log[$], datab_log[$], gap_log[$], rv_log[$], ri_log[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        gap_run <= ci_clk_en ? 0 : gap_run + 1;
        if (ci_start) begin
            n_start <= n_start + 1;
            start_cyc <= cyc;
            dataa_log.push_back(int'(ci_dataa));
            datab_log.push_back(int'(ci_datab));
            gap_log.push_back(gap_run);
        end
        if (roll_valid) begin
            n_roll <= n_roll + 1;
            roll_cyc <= cyc;
            rv_log.push_back(int'(roll_value));
            ri_log.push_back(int'(roll_index));
        end
        if (sum_valid) begin
            n_sum <= n_sum + 1;
            sum_cyc <= cyc;
            last_sum <= int'(sum_value);
        end
        if (err) begin
            n_err <= n_err + 1;
            err_cyc <= cyc;
            last_err_code <= int'(err_code);
        end
    end

    task automatic send(input logic [3:0] die, input logic [3:0] cnt);
        @(posedge clk); #1;
        cmd_valid = 1; cmd_die = die; cmd_count = cnt;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_die = 0; cmd_count = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bs, br, bsum, be, hi;
    logic [31:0] bad_vals [3];

    initial begin
        reset_n = 1; cmd_valid = 0; cmd_die = 0; cmd_count = 0;
        #2 reset_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_ci_start", int'(ci_start), 0);
        chk("rst_ci_clk_en", int'(ci_clk_en), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_outs", int'({roll_valid, sum_valid, err, roll_value, roll_index}), 0);
        chk("rst_sum_value", int'(sum_value), 0);
        @(posedge clk); #1 reset_n = 1;
        settle(2);

        // Single D20 roll, result 17 after 3 cycles
        slave_lat = 3; slave_q.push_back(32'd17);
        bs = n_start; br = n_roll; bsum = n_sum; be = n_err;
        send(4'd5, 4'd1);
        settle(15);
        chk("d20_starts", n_start - bs, 1);
        chk("d20_dataa", dataa_log[bs], 5);
        chk("d20_datab", datab_log[bs], 0);
        chk("d20_rolls", n_roll - br, 1);
        chk("d20_value", rv_log[br], 17);
        chk("d20_index", ri_log[br], 1);
        chk("d20_roll_lat", roll_cyc - start_cyc, 4);
        chk("d20_sums", n_sum - bsum, 1);
        chk("d20_sum", last_sum, 17);
        chk("d20_sum_lat", sum_cyc - roll_cyc, 1);
        chk("d20_no_err", n_err - be, 0);
        chk("d20_hold_value", int'(roll_value), 17);

        // Batch of 3 D6: 6, 1, 4 -> sum 11
        slave_q.push_back(32'd6); slave_q.push_back(32'd1); slave_q.push_back(32'd4);
        bs = n_start; br = n_roll; bsum = n_sum; be = n_err;
        send(4'd1, 4'd3);
        hi = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (cmd_ready) hi++;
        end
        chk("d6_ready_low", hi, 0);
        settle(10);
        chk("d6_starts", n_start - bs, 3);
        chk("d6_values", rv_log[br] * 10000 + rv_log[br+1] * 100 + rv_log[br+2], 60104);
        chk("d6_indices", ri_log[br] * 100 + ri_log[br+1] * 10 + ri_log[br+2], 123);
        chk("d6_gap2", int'(gap_log[bs+1] >= GAP), 1);
        chk("d6_gap3", int'(gap_log[bs+2] >= GAP), 1);
        chk("d6_sum", last_sum, 11);
        chk("d6_sums", n_sum - bsum, 1);
        chk("d6_ready_after", int'(cmd_ready), 1);

        // Bad commands: die 9, then count 0
        bs = n_start; be = n_err;
        send(4'd9, 4'd2);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!cmd_ready) hi++;
        end
        chk("bad_die_err", n_err - be, 1);
        chk("bad_die_code", last_err_code, 1);
        chk("bad_die_ready", hi, 0);
        chk("bad_die_code_held", int'(err_code), 1);
        send(4'd2, 4'd0);
        settle(4);
        chk("bad_cnt_err", n_err - be, 2);
        chk("bad_cnt_code", last_err_code, 1);
        chk("bad_no_start", n_start - bs, 0);

        // Timeout: done arrives only after 70 cycles
        slave_lat = 70;
        bs = n_start; br = n_roll; bsum = n_sum; be = n_err;
        send(4'd0, 4'd1);
        settle(90);
        chk("tmo_err", n_err - be, 1);
        chk("tmo_code", last_err_code, 2);
        chk("tmo_latency", err_cyc - start_cyc, TMO);
        chk("tmo_no_roll", n_roll - br, 0);
        chk("tmo_no_sum", n_sum - bsum, 0);
        chk("tmo_starts", n_start - bs, 1);
        slave_lat = 2; slave_q.push_back(32'd3);
        send(4'd0, 4'd1);
        settle(12);
        chk("post_tmo_value", rv_log[br], 3);
        chk("post_tmo_sum", last_sum, 3);
        chk("post_tmo_code_clr", int'(err_code), 0);
        chk("post_tmo_no_err", n_err - be, 1);

        // Out of range on D8: 0, 9, upper bits set; then boundary 8 accepted
        slave_lat = 1;
        bad_vals[0] = 32'd0; bad_vals[1] = 32'd9; bad_vals[2] = 32'h0000_0083;
        for (int k = 0; k < 3; k++) begin
            br = n_roll; bsum = n_sum; be = n_err;
            slave_q.push_back(bad_vals[k]);
            send(4'd2, 4'd1);
            settle(10);
            chk($sformatf("oor%0d_err", k), n_err - be, 1);
            chk($sformatf("oor%0d_code", k), last_err_code, 3);
            chk($sformatf("oor%0d_no_roll", k), (n_roll - br) + (n_sum - bsum), 0);
        end
        slave_q.push_back(32'd8);
        br = n_roll;
        send(4'd2, 4'd1);
        settle(10);
        chk("d8_max_value", rv_log[br], 8);
        chk("d8_max_sum", last_sum, 8);

        // Zero-latency slave, D100 boundaries: 100 + 1 = 101
        slave_lat = 0; slave_q.push_back(32'd100); slave_q.push_back(32'd1);
        bs = n_start; br = n_roll; be = n_err;
        send(4'd6, 4'd2);
        settle(30);
        chk("zl_dataa", dataa_log[bs], 6);
        chk("zl_values", rv_log[br] * 1000 + rv_log[br+1], 100001);
        chk("zl_roll_lat", roll_cyc - start_cyc, 1);
        chk("zl_sum", last_sum, 101);
        chk("zl_no_err", n_err - be, 0);

        // Reset during WAIT of roll 2 of a 4-roll batch
        slave_lat = 3; slave_q.push_back(32'd2); slave_q.push_back(32'd5);
        bs = n_start; bsum = n_sum; be = n_err;
        send(4'd1, 4'd4);
        for (int i = 0; i < 40 && n_start < bs + 2; i++) @(posedge clk);
        chk("rst_mid_reach", n_start - bs, 2);
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("rst_mid_ready", int'(cmd_ready), 1);
        chk("rst_mid_clk_en", int'(ci_clk_en), 0);
        chk("rst_mid_roll", int'({roll_value, roll_index}), 0);
        chk("rst_mid_sum_value", int'(sum_value), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        settle(20);
        chk("rst_mid_no_err", n_err - be, 0);
        chk("rst_mid_no_sum", n_sum - bsum, 0);
        chk("rst_mid_no_start", n_start - bs, 2);
        slave_q.delete();
        slave_lat = 2; slave_q.push_back(32'd4);
        br = n_roll;
        send(4'd0, 4'd1);
        settle(12);
        chk("rst_mid_recover", last_sum, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
